// File: rtl/adder_pkg.sv
// Shared types for the 5-bit prefix adder and its downstream result FIFO.
package adder_pkg;

  localparam int ADD_WIDTH = 5;

  typedef struct packed {
    logic                 cout;
    logic [ADD_WIDTH-1:0] sum;
  } adder_result_t;

endpackage

// File: rtl/adder_result_mem.sv
// Result storage: DEPTH x adder_result_t register array.
// One synchronous write port, one asynchronous read port, no reset.
module adder_result_mem
  import adder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  adder_result_t wdata,
  input  logic [AW-1:0] raddr,
  output adder_result_t rdata
);

  adder_result_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/adder_result_fifo.sv
// First-word-fall-through FIFO for {cout, sum} adder results.
// ADDER_RESULT_STATS_EN adds a saturating carry-out counter (carry_cnt).
module adder_result_fifo
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_sum,
  input  logic                       in_cout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_sum,
  output logic                       out_cout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
`ifdef ADDER_RESULT_STATS_EN
  ,
  output logic [CNT_W-1:0]           carry_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  adder_result_t wr_data;
  adder_result_t head;

  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
              && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;

  assign in_ready  = !full;
  assign out_valid = !empty;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  assign wr_data.cout = in_cout;
  assign wr_data.sum  = in_sum;

  // Head is masked so stale storage never leaks while empty.
  assign out_sum  = empty ? '0 : head.sum;
  assign out_cout = empty ? 1'b0 : head.cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  adder_result_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );

`ifdef ADDER_RESULT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_cnt <= '0;
    end else if (push && in_cout && (carry_cnt != '1)) begin
      carry_cnt <= carry_cnt + 1'b1;
    end
  end
`endif

endmodule
